// File: rtl/cus43_layer_shifter.sv
// cus43_layer_shifter: per-layer pixel serialiser.
// A 4-pixel slice is loaded from the tile PROM data on S3H. One 11-bit dot
// {colour, pen} is then emitted per CLK_6M, through a registered output stage.
// Optional macro CUS43_SYNC_CHECK_EN builds the sticky SYNC_ERR fault flag.
// When the macro is undefined, SYNC_ERR is tied low.
module cus43_layer_shifter #(
    parameter int         ASSIGNED_LAYER  = 0,
    parameter logic [2:0] TRANSPARENT_PEN = 3'd7
) (
    input  logic        CLK_6M,
    input  logic        nRST,
    input  logic        FLIP,
    input  logic        S3H,
    input  logic        ATTR_LATCH,
    input  logic [7:0]  ATTR,
    input  logic [7:0]  GD,
    input  logic [3:0]  GDH,
    input  logic        BLANK,
    output logic [10:0] DOT,
    output logic        TRANSP,
    output logic        SYNC_ERR
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        UNDERRUN = 2'd2
    } state_t;

    state_t      state_q;
    logic [1:0]  slot_q;
    logic [2:0]  pens_q [4];
    logic [7:0]  pend_q;
    logic [7:0]  colour_q;
    logic [10:0] dot_q;
    logic        transp_q;

    logic [2:0]  rawPen [4];
    logic [2:0]  slicePen [4];
    logic [2:0]  outPen;

    // The layer index only names a debug scope; it has no behavioural effect.
    if (ASSIGNED_LAYER == 0) begin : g_layer0
    end else begin : g_layer1
    end

    // Gather the slice pens in emission order, so FLIP only matters at load time.
    always_comb begin
        rawPen[0]   = {GDH[3], GD[3], GD[7]};
        rawPen[1]   = {GDH[2], GD[2], GD[6]};
        rawPen[2]   = {GDH[1], GD[1], GD[5]};
        rawPen[3]   = {GDH[0], GD[0], GD[4]};
        slicePen[0] = FLIP ? rawPen[3] : rawPen[0];
        slicePen[1] = FLIP ? rawPen[2] : rawPen[1];
        slicePen[2] = FLIP ? rawPen[1] : rawPen[2];
        slicePen[3] = FLIP ? rawPen[0] : rawPen[3];
    end

    // Pen for this cycle's output: the current slot when shifting, otherwise transparent.
    // BLANK overrides the pen without disturbing the shifter.
    always_comb begin
        outPen = TRANSPARENT_PEN;
        if (state_q == SHIFT) begin
            outPen = pens_q[slot_q];
        end
        if (BLANK) begin
            outPen = TRANSPARENT_PEN;
        end
    end

    // Slice FSM, attribute registers and registered dot output.
    // Any S3H reloads the slice, whatever the state.
    always_ff @(posedge CLK_6M) begin
        if (!nRST) begin
            state_q  <= IDLE;
            slot_q   <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                pens_q[i] <= 3'd0;
            end
            pend_q   <= 8'd0;
            colour_q <= 8'd0;
            dot_q    <= 11'd0;
            transp_q <= 1'b1;
        end else begin
            dot_q    <= {colour_q, outPen};
            transp_q <= (outPen == TRANSPARENT_PEN);
            if (ATTR_LATCH) begin
                pend_q <= ATTR;
            end
            if (S3H) begin
                state_q  <= SHIFT;
                slot_q   <= 2'd0;
                colour_q <= pend_q;
                for (int i = 0; i < 4; i++) begin
                    pens_q[i] <= slicePen[i];
                end
            end else if (state_q == SHIFT) begin
                if (slot_q == 2'd3) begin
                    state_q <= UNDERRUN;
                end else begin
                    slot_q <= slot_q + 2'd1;
                end
            end
        end
    end

    assign DOT    = dot_q;
    assign TRANSP = transp_q;

`ifdef CUS43_SYNC_CHECK_EN
    logic syncErr_q;
    logic syncFault;

    // A fault is S3H arriving at any slot other than the last one, or S3H missing at the last slot.
    always_comb begin
        syncFault = (state_q == SHIFT) && (S3H != (slot_q == 2'd3));
    end

    // Sticky fault flag; only reset clears it.
    always_ff @(posedge CLK_6M) begin
        if (!nRST) begin
            syncErr_q <= 1'b0;
        end else if (syncFault) begin
            syncErr_q <= 1'b1;
        end
    end

    assign SYNC_ERR = syncErr_q;
`else
    assign SYNC_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_cus43_layer_shifter.sv
// Testbench for cus43_layer_shifter.
// A reference model tracks the pixels still owed as a queue of {colour, pen} words.
// Stimulus comes from directed scenarios and from $urandom.
module tb_cus43_layer_shifter;

    localparam logic [2:0] TP = 3'd7;

    logic        CLK_6M = 1'b0;
    logic        nRST = 1'b0;
    logic        FLIP = 1'b0;
    logic        S3H = 1'b0;
    logic        ATTR_LATCH = 1'b0;
    logic [7:0]  ATTR = 8'd0;
    logic [7:0]  GD = 8'd0;
    logic [3:0]  GDH = 4'd0;
    logic        BLANK = 1'b0;
    logic [10:0] DOT;
    logic        TRANSP;
    logic        SYNC_ERR;

    int errors = 0;
    int checks = 0;

    logic [10:0] expQ[$];
    logic [7:0]  mPend = 8'd0;
    logic [7:0]  mColour = 8'd0;
    logic [10:0] mDot = 11'd0;
    logic        mTransp = 1'b1;
    logic        mSync = 1'b0;

    cus43_layer_shifter #(.ASSIGNED_LAYER(0), .TRANSPARENT_PEN(TP)) dut (
        .CLK_6M(CLK_6M), .nRST(nRST), .FLIP(FLIP), .S3H(S3H),
        .ATTR_LATCH(ATTR_LATCH), .ATTR(ATTR), .GD(GD), .GDH(GDH),
        .BLANK(BLANK), .DOT(DOT), .TRANSP(TRANSP), .SYNC_ERR(SYNC_ERR)
    );

    always #5 CLK_6M = ~CLK_6M;

    // Pen of slice pixel k, taken straight from the PROM bit layout.
    function automatic logic [2:0] slicePen(input logic [7:0] gd, input logic [3:0] gdh, input int k);
        logic [1:0] kk;
        logic [1:0] hi;
        logic [2:0] lo0;
        logic [2:0] lo1;
        kk  = 2'(k);
        hi  = 2'd3 - kk;
        lo1 = {1'b0, hi};
        lo0 = 3'd7 - {1'b0, kk};
        return {gdh[hi], gd[lo1], gd[lo0]};
    endfunction

    // One clock edge of the reference model, using the inputs present at that edge.
    task automatic modelEdge();
        logic [10:0] w;
        logic [2:0]  pen;
        logic [7:0]  col;
        logic        popped;
        if (!nRST) begin
            expQ.delete();
            mPend   = 8'd0;
            mColour = 8'd0;
            mDot    = 11'd0;
            mTransp = 1'b1;
            mSync   = 1'b0;
        end else begin
            popped = 1'b0;
            if (expQ.size() > 0) begin
                w      = expQ.pop_front();
                col    = w[10:3];
                pen    = w[2:0];
                popped = 1'b1;
            end else begin
                col = mColour;
                pen = TP;
            end
            if (BLANK) pen = TP;
            mDot    = {col, pen};
            mTransp = (pen == TP);
            if (S3H) begin
`ifdef CUS43_SYNC_CHECK_EN
                if (expQ.size() > 0) mSync = 1'b1;
`endif
                expQ.delete();
                mColour = mPend;
                for (int k = 0; k < 4; k++) begin
                    expQ.push_back({mPend, slicePen(GD, GDH, FLIP ? 3 - k : k)});
                end
            end else begin
`ifdef CUS43_SYNC_CHECK_EN
                if (popped && expQ.size() == 0) mSync = 1'b1;
`endif
            end
            if (ATTR_LATCH) mPend = ATTR;
        end
    endtask

    task automatic step();
        @(posedge CLK_6M);
        modelEdge();
        #1;
    endtask

    task automatic applyQuiet();
        S3H        = 1'b0;
        ATTR_LATCH = 1'b0;
        BLANK      = 1'b0;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        S3H  = 1'b1;
        GD   = 8'hF0;
        step();
        step();
        checks += 3;
        if (DOT !== 11'h000) begin errors++; $display("[TB] FAIL reset_dot got %h want %h", DOT, 11'h000); end
        if (TRANSP !== 1'b1) begin errors++; $display("[TB] FAIL reset_transp got %b want 1", TRANSP); end
        if (SYNC_ERR !== 1'b0) begin errors++; $display("[TB] FAIL reset_syncerr got %b want 0", SYNC_ERR); end
        nRST = 1'b1;
        applyQuiet();
        step();
        checks += 2;
        if (DOT !== 11'h007) begin errors++; $display("[TB] FAIL idle_dot got %h want %h", DOT, 11'h007); end
        if (TRANSP !== 1'b1) begin errors++; $display("[TB] FAIL idle_transp got %b want 1", TRANSP); end
    endtask

    task automatic test_single_slice();
        ATTR_LATCH = 1'b1; ATTR = 8'h12;
        step();
        ATTR_LATCH = 1'b0; S3H = 1'b1; GD = 8'hF0; GDH = 4'h0; FLIP = 1'b0;
        step();
        applyQuiet();
        for (int c = 0; c < 6; c++) begin
            step();
            checks += 3;
            if (DOT !== mDot) begin errors++; $display("[TB] FAIL single_dot c%0d got %h want %h", c, DOT, mDot); end
            if (TRANSP !== mTransp) begin errors++; $display("[TB] FAIL single_transp c%0d got %b want %b", c, TRANSP, mTransp); end
            if (SYNC_ERR !== mSync) begin errors++; $display("[TB] FAIL single_sync c%0d got %b want %b", c, SYNC_ERR, mSync); end
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 48; c++) begin
            S3H        = (c % 4 == 0);
            GD         = 8'($urandom);
            GDH        = 4'($urandom);
            FLIP       = 1'($urandom);
            ATTR_LATCH = 1'($urandom);
            ATTR       = 8'($urandom);
            step();
            checks += 3;
            if (DOT !== mDot) begin errors++; $display("[TB] FAIL b2b_dot c%0d got %h want %h", c, DOT, mDot); end
            if (TRANSP !== mTransp) begin errors++; $display("[TB] FAIL b2b_transp c%0d got %b want %b", c, TRANSP, mTransp); end
            if (SYNC_ERR !== mSync) begin errors++; $display("[TB] FAIL b2b_sync c%0d got %b want %b", c, SYNC_ERR, mSync); end
        end
        applyQuiet();
    endtask

    task automatic test_flip_attr();
        ATTR_LATCH = 1'b1; ATTR = 8'h12;
        step();
        for (int c = 0; c < 10; c++) begin
            S3H        = (c == 0 || c == 4);
            ATTR_LATCH = (c == 0);
            ATTR       = 8'hAB;
            GD         = 8'h84;
            GDH        = 4'h2;
            FLIP       = (c == 0);
            step();
            checks += 3;
            if (DOT !== mDot) begin errors++; $display("[TB] FAIL flipattr_dot c%0d got %h want %h", c, DOT, mDot); end
            if (TRANSP !== mTransp) begin errors++; $display("[TB] FAIL flipattr_transp c%0d got %b want %b", c, TRANSP, mTransp); end
            if (SYNC_ERR !== mSync) begin errors++; $display("[TB] FAIL flipattr_sync c%0d got %b want %b", c, SYNC_ERR, mSync); end
        end
        applyQuiet();
    endtask

    task automatic test_blank_transparent();
        for (int c = 0; c < 10; c++) begin
            S3H   = (c == 0 || c == 4);
            GD    = (c == 0) ? 8'hFF : 8'hF0;
            GDH   = (c == 0) ? 4'hF : 4'h0;
            BLANK = (c == 6);
            step();
            checks += 3;
            if (DOT !== mDot) begin errors++; $display("[TB] FAIL blank_dot c%0d got %h want %h", c, DOT, mDot); end
            if (TRANSP !== mTransp) begin errors++; $display("[TB] FAIL blank_transp c%0d got %b want %b", c, TRANSP, mTransp); end
            if (SYNC_ERR !== mSync) begin errors++; $display("[TB] FAIL blank_sync c%0d got %b want %b", c, SYNC_ERR, mSync); end
        end
        applyQuiet();
    endtask

    task automatic test_early_reload();
        nRST = 1'b0;
        step();
        nRST = 1'b1;
        for (int c = 0; c < 8; c++) begin
            S3H  = (c == 0 || c == 2);
            GD   = (c == 0) ? 8'hF0 : 8'h0F;
            GDH  = 4'h0;
            FLIP = 1'b0;
            step();
            checks += 3;
            if (DOT !== mDot) begin errors++; $display("[TB] FAIL early_dot c%0d got %h want %h", c, DOT, mDot); end
            if (TRANSP !== mTransp) begin errors++; $display("[TB] FAIL early_transp c%0d got %b want %b", c, TRANSP, mTransp); end
            if (SYNC_ERR !== mSync) begin errors++; $display("[TB] FAIL early_sync c%0d got %b want %b", c, SYNC_ERR, mSync); end
        end
        applyQuiet();
        nRST = 1'b0;
        step();
        nRST = 1'b1;
        checks += 2;
        if (SYNC_ERR !== 1'b0) begin errors++; $display("[TB] FAIL early_sync_cleared got %b want 0", SYNC_ERR); end
        if (DOT !== 11'h000) begin errors++; $display("[TB] FAIL early_reset_dot got %h want %h", DOT, 11'h000); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            nRST       = ($urandom_range(0, 99) >= 2);
            S3H        = ($urandom_range(0, 99) < 30);
            BLANK      = ($urandom_range(0, 99) < 10);
            ATTR_LATCH = ($urandom_range(0, 99) < 20);
            ATTR       = 8'($urandom);
            GD         = 8'($urandom);
            GDH        = 4'($urandom);
            FLIP       = 1'($urandom);
            step();
            checks += 3;
            if (DOT !== mDot) begin errors++; $display("[TB] FAIL rand_dot c%0d got %h want %h", c, DOT, mDot); end
            if (TRANSP !== mTransp) begin errors++; $display("[TB] FAIL rand_transp c%0d got %b want %b", c, TRANSP, mTransp); end
            if (SYNC_ERR !== mSync) begin errors++; $display("[TB] FAIL rand_sync c%0d got %b want %b", c, SYNC_ERR, mSync); end
        end
        nRST = 1'b1;
        applyQuiet();
    endtask

    initial begin
        #2;
        test_reset();
        test_single_slice();
        test_back_to_back();
        test_flip_attr();
        test_blank_transparent();
        test_early_reload();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
